id_ex_hazard_reg: RTL and testbench
===================================

Name: id_ex_hazard_reg

Overview:
ID/EX pipeline boundary for the 5-stage MIPS core. Sits directly downstream of the main opcode decoder.
- Registers the decoder's control bits together with the decode-stage operands.
- Detects load-use hazards against the instruction currently in EX; on a hazard it stalls PC and IF/ID and inserts a bubble.
- Accepts a branch flush, which also converts the captured instruction into a bubble.

Parameters:
DATA_W, 32, width of register-file data, immediate and PC.
RA_W, 5, register address width.

Ports:
clk  in  1  system clock; all state updates on its rising edge.
rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch  in  1 each  decoder control bits.
id_ALUOp  in  2  {ALUOp1, ALUOp0} from the decoder.
id_rd1, id_rd2  in  DATA_W  register-file read data.
id_imm  in  DATA_W  sign-extended immediate.
id_pc4  in  DATA_W  PC+4 of the decode instruction.
id_rs, id_rt, id_rd  in  RA_W  instruction register fields.
flush  in  1  branch taken in EX/MEM; kill the decode-stage instruction.
ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch  out  1 each  registered control bits.
ex_ALUOp  out  2  registered ALUOp.
ex_rd1, ex_rd2, ex_imm, ex_pc4  out  DATA_W  registered datapath values.
ex_rs, ex_rt, ex_rd  out  RA_W  registered register fields.
ex_valid  out  1  1 = EX holds a real instruction; 0 = bubble.
pc_write  out  1  combinational; 0 holds the PC.
ifid_write  out  1  combinational; 0 holds the IF/ID register.
stall_cnt  out  16  only when HAZARD_STAT_EN is defined.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous, active-low (rst_n).
- Reset values: when rst_n=0 at a rising edge, all ex_* outputs, ex_valid and stall_cnt go to 0. An in-flight instruction is discarded; there is no partial state.
- Hazard term (combinational): hazard = ex_MemRead & ex_valid & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)).
  - The comparison is applied for every opcode, including lw/sw/beq. Over-stalling is accepted.
- Stall outputs: pc_write = ifid_write = ~hazard.
  - While rst_n=0, outputs follow the current register state; after the reset edge, pc_write = 1.
- Per-edge update priority: rst_n=0 > flush > hazard > normal.
  - flush=1: bubble. All control bits and ALUOp are 0, ex_valid=0; datapath fields are don't-care but are driven to 0. flush with a simultaneous hazard still yields a bubble, and pc_write/ifid_write still deassert that cycle.
  - hazard=1: bubble loaded, as for flush. The decode instruction stays in IF/ID because ifid_write=0. The next cycle, the EX instruction is a bubble, so hazard clears and the held instruction is captured. A load-use therefore costs exactly 1 cycle.
  - Normal: all id_* inputs are captured into ex_*, and ex_valid=1.
- Latency: 1 cycle from id_* to ex_*.
- No multi-cycle FSM beyond the implicit two-state NORMAL/BUBBLE driven by hazard. Back-to-back loads into dependent uses each cost 1 stall.
- $zero: a destination of register 0 never triggers a stall.

Optional Feature:
HAZARD_STAT_EN.
- Defined: stall_cnt port exists.
  - Increments by 1 on each edge where hazard=1 and rst_n=1. flush does not count.
  - Saturates at 16'hFFFF; no wrap-around.
  - Reset to 0 by rst_n.
- Undefined: stall_cnt port and counter are absent. All other behaviour is identical.

Test Plan:
1. Reset: hold rst_n=0 two cycles with random id_* -> all ex_* = 0, ex_valid=0, pc_write=1 after the reset edge.
2. Pass-through: R-format (RegDst=1, RegWrite=1, ALUOp=2'b10), id_rd1=32'h11, id_rd2=32'h22, rs=1, rt=2, rd=3 -> next edge ex_* match, ex_valid=1, no stall.
3. Load-use: lw with rt=5 captured, then add with rs=5 in decode -> pc_write=ifid_write=0 for one cycle. Next ex_* are a bubble (all controls 0, ex_valid=0). The following edge captures the add.
4. $zero: lw with rt=0, then an instruction with rs=0 -> no stall, normal capture.
5. Flush: flush=1 while decode holds sw -> ex_MemWrite=0, ex_valid=0. flush together with a hazard -> bubble, pc_write=0 that cycle.
6. HAZARD_STAT_EN: 3 load-use stalls -> stall_cnt=3. Preload near saturation (force 16'hFFFE, 2 stalls) -> stall_cnt=16'hFFFF and holds. rst_n=0 mid-stall -> stall_cnt=0 and ex_valid=0.

Source files
------------

// File: rtl/id_ex_hazard_reg.sv
// rtl/id_ex_hazard_reg.sv - ID/EX pipeline register with load-use stall and flush bubble (optional HAZARD_STAT_EN stall counter)
module id_ex_hazard_reg #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_RegDst,
    input  logic              id_ALUSrc,
    input  logic              id_MemtoReg,
    input  logic              id_RegWrite,
    input  logic              id_MemRead,
    input  logic              id_MemWrite,
    input  logic              id_Branch,
    input  logic [1:0]        id_ALUOp,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [RA_W-1:0]   id_rs,
    input  logic [RA_W-1:0]   id_rt,
    input  logic [RA_W-1:0]   id_rd,
    input  logic              flush,
    output logic              ex_RegDst,
    output logic              ex_ALUSrc,
    output logic              ex_MemtoReg,
    output logic              ex_RegWrite,
    output logic              ex_MemRead,
    output logic              ex_MemWrite,
    output logic              ex_Branch,
    output logic [1:0]        ex_ALUOp,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [RA_W-1:0]   ex_rs,
    output logic [RA_W-1:0]   ex_rt,
    output logic [RA_W-1:0]   ex_rd,
    output logic              ex_valid,
    output logic              pc_write,
    output logic              ifid_write
`ifdef HAZARD_STAT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    logic hazard;

    // Compared for every opcode; over-stalling on sw/beq is harmless.
    always_comb begin
        hazard = ex_MemRead & ex_valid & (ex_rt != '0) &
                 ((ex_rt == id_rs) | (ex_rt == id_rt));
    end

    assign pc_write   = ~hazard;
    assign ifid_write = ~hazard;

    always_ff @(posedge clk) begin
        if (!rst_n || flush || hazard) begin
            ex_RegDst   <= 1'b0;
            ex_ALUSrc   <= 1'b0;
            ex_MemtoReg <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_MemWrite <= 1'b0;
            ex_Branch   <= 1'b0;
            ex_ALUOp    <= 2'b00;
            ex_rd1      <= '0;
            ex_rd2      <= '0;
            ex_imm      <= '0;
            ex_pc4      <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
            ex_valid    <= 1'b0;
        end else begin
            ex_RegDst   <= id_RegDst;
            ex_ALUSrc   <= id_ALUSrc;
            ex_MemtoReg <= id_MemtoReg;
            ex_RegWrite <= id_RegWrite;
            ex_MemRead  <= id_MemRead;
            ex_MemWrite <= id_MemWrite;
            ex_Branch   <= id_Branch;
            ex_ALUOp    <= id_ALUOp;
            ex_rd1      <= id_rd1;
            ex_rd2      <= id_rd2;
            ex_imm      <= id_imm;
            ex_pc4      <= id_pc4;
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
            ex_rd       <= id_rd;
            ex_valid    <= 1'b1;
        end
    end

`ifdef HAZARD_STAT_EN
    logic [15:0] cnt_q;

    // Counts hazard stalls only (flush is not a stall), saturating.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 16'h0000;
        end else if (hazard && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'h0001;
        end
    end

    assign stall_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// tb/tb_id_ex_hazard_reg.sv - randomized self-checking bench for id_ex_hazard_reg against a behavioural model
module tb_id_ex_hazard_reg;

    localparam int DATA_W = 32;
    localparam int RA_W   = 5;
    localparam int OBS_W  = 9 + 4 * DATA_W + 3 * RA_W + 1;

    logic clk = 1'b0;
    logic rst_n;
    logic [8:0] i_ctrl;
    logic [DATA_W-1:0] i_rd1, i_rd2, i_imm, i_pc4;
    logic [RA_W-1:0] i_rs, i_rt, i_rd;
    logic flush;

    logic ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch;
    logic [1:0] ex_ALUOp;
    logic [DATA_W-1:0] ex_rd1, ex_rd2, ex_imm, ex_pc4;
    logic [RA_W-1:0] ex_rs, ex_rt, ex_rd;
    logic ex_valid, pc_write, ifid_write;
`ifdef HAZARD_STAT_EN
    logic [15:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    id_ex_hazard_reg #(.DATA_W(DATA_W), .RA_W(RA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_RegDst(i_ctrl[8]), .id_ALUSrc(i_ctrl[7]), .id_MemtoReg(i_ctrl[6]),
        .id_RegWrite(i_ctrl[5]), .id_MemRead(i_ctrl[4]), .id_MemWrite(i_ctrl[3]),
        .id_Branch(i_ctrl[2]), .id_ALUOp(i_ctrl[1:0]),
        .id_rd1(i_rd1), .id_rd2(i_rd2), .id_imm(i_imm), .id_pc4(i_pc4),
        .id_rs(i_rs), .id_rt(i_rt), .id_rd(i_rd), .flush(flush),
        .ex_RegDst(ex_RegDst), .ex_ALUSrc(ex_ALUSrc), .ex_MemtoReg(ex_MemtoReg),
        .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_Branch(ex_Branch), .ex_ALUOp(ex_ALUOp),
        .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_valid(ex_valid), .pc_write(pc_write), .ifid_write(ifid_write)
`ifdef HAZARD_STAT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    // Instruction classes as {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUOp}
    localparam logic [8:0] C_RTYPE = 9'b1_0_0_1_0_0_0_10;
    localparam logic [8:0] C_LW    = 9'b0_1_1_1_1_0_0_00;
    localparam logic [8:0] C_SW    = 9'b0_1_0_0_0_1_0_00;
    localparam logic [8:0] C_BEQ   = 9'b0_0_0_0_0_0_1_01;

    // Behavioural model: the instruction currently in EX (a bubble is all zero).
    typedef struct packed {
        logic [8:0]        ctrl;
        logic [DATA_W-1:0] rd1, rd2, imm, pc4;
        logic [RA_W-1:0]   rs, rt, rd;
        logic              valid;
    } ex_t;

    ex_t m_ex;
    int  m_cnt;
    int  checks = 0;
    int  errors = 0;
    logic [OBS_W-1:0] obs;

    assign obs = {ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite,
                  ex_Branch, ex_ALUOp, ex_rd1, ex_rd2, ex_imm, ex_pc4, ex_rs, ex_rt, ex_rd, ex_valid};

    // A load sitting in EX whose destination (nonzero) is read by the decode instruction.
    function automatic logic model_stall();
        return m_ex.valid && m_ex.ctrl[4] && (m_ex.rt != 0) &&
               (m_ex.rt == i_rs || m_ex.rt == i_rt);
    endfunction

    task automatic set_instr(input logic [8:0] c, input int rs, input int rt, input int rd);
        i_ctrl = c;
        i_rs   = RA_W'(rs);
        i_rt   = RA_W'(rt);
        i_rd   = RA_W'(rd);
        i_rd1  = $urandom;
        i_rd2  = $urandom;
        i_imm  = $urandom;
        i_pc4  = $urandom;
    endtask

    task automatic step();
        logic stall;
        #1;
        stall = model_stall();
        @(posedge clk);
        if (!rst_n) begin
            m_ex  = '0;
            m_cnt = 0;
        end else if (flush || stall) begin
            m_ex = '0;
            if (stall && m_cnt < 16'hFFFF) m_cnt++;
        end else begin
            m_ex = '{ctrl: i_ctrl, rd1: i_rd1, rd2: i_rd2, imm: i_imm, pc4: i_pc4,
                     rs: i_rs, rt: i_rt, rd: i_rd, valid: 1'b1};
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_instr(9'($urandom), $urandom, $urandom, $urandom);
            step();
        end
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_state got=%h exp=0", obs);
        end
        rst_n = 1'b1;
        set_instr(C_RTYPE, 1, 2, 3);
        #1;
        checks++;
        if (pc_write !== 1'b1) begin
            errors++;
            $display("FAIL reset_pc_write got=%b exp=1", pc_write);
        end
    endtask

    task automatic test_pass_through();
        set_instr(C_RTYPE, 1, 2, 3);
        i_rd1 = 32'h11;
        i_rd2 = 32'h22;
        step();
        checks++;
        if (obs !== m_ex || ex_valid !== 1'b1 || ex_rd1 !== 32'h11 || ex_rd2 !== 32'h22 ||
            ex_ALUOp !== 2'b10 || ex_RegDst !== 1'b1) begin
            errors++;
            $display("FAIL pass_through got=%h exp=%h", obs, m_ex);
        end
        checks++;
        if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin
            errors++;
            $display("FAIL pass_through_stall got=%b%b exp=11", pc_write, ifid_write);
        end
    endtask

    task automatic test_load_use();
        set_instr(C_LW, 1, 5, 0);
        step();
        set_instr(C_RTYPE, 5, 6, 7);
        #1;
        checks++;
        if (pc_write !== 1'b0 || ifid_write !== 1'b0) begin
            errors++;
            $display("FAIL load_use_stall got=%b%b exp=00", pc_write, ifid_write);
        end
        step();
        checks++;
        if (ex_valid !== 1'b0 || obs[OBS_W-1 -: 9] !== 9'h0) begin
            errors++;
            $display("FAIL load_use_bubble got=%h exp=0 ctrl and valid", obs);
        end
        checks++;
        if (pc_write !== 1'b1) begin
            errors++;
            $display("FAIL load_use_release got=%b exp=1", pc_write);
        end
        step();
        checks++;
        if (obs !== m_ex || ex_rs !== 5'd5 || ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL load_use_capture got=%h exp=%h", obs, m_ex);
        end
    endtask

    task automatic test_zero_reg();
        set_instr(C_LW, 4, 0, 0);
        step();
        set_instr(C_RTYPE, 0, 0, 9);
        #1;
        checks++;
        if (pc_write !== 1'b1) begin
            errors++;
            $display("FAIL zero_no_stall got=%b exp=1", pc_write);
        end
        step();
        checks++;
        if (obs !== m_ex || ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL zero_capture got=%h exp=%h", obs, m_ex);
        end
    endtask

    task automatic test_flush();
        set_instr(C_SW, 2, 3, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (ex_MemWrite !== 1'b0 || ex_valid !== 1'b0 || obs !== '0) begin
            errors++;
            $display("FAIL flush_sw got=%h exp=0", obs);
        end
        set_instr(C_LW, 1, 7, 0);
        step();
        set_instr(C_BEQ, 7, 2, 0);
        flush = 1'b1;
        #1;
        checks++;
        if (pc_write !== 1'b0 || ifid_write !== 1'b0) begin
            errors++;
            $display("FAIL flush_hazard_stall got=%b%b exp=00", pc_write, ifid_write);
        end
        step();
        flush = 1'b0;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL flush_hazard_bubble got=%h exp=0", obs);
        end
    endtask

    task automatic test_random();
        logic [8:0] kinds [4];
        logic exp_stall;
        kinds = '{C_RTYPE, C_LW, C_SW, C_BEQ};
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            flush = ($urandom_range(0, 7) == 0);
            set_instr(kinds[$urandom_range(0, 3)], $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom);
            #1;
            exp_stall = model_stall();
            checks++;
            if (pc_write !== !exp_stall || ifid_write !== !exp_stall) begin
                errors++;
                $display("FAIL rand_stall n=%0d got=%b%b exp=%b", n, pc_write, ifid_write, !exp_stall);
            end
            step();
            checks++;
            if (obs !== m_ex) begin
                errors++;
                $display("FAIL rand_ex n=%0d got=%h exp=%h", n, obs, m_ex);
            end
`ifdef HAZARD_STAT_EN
            checks++;
            if (stall_cnt !== 16'(m_cnt)) begin
                errors++;
                $display("FAIL rand_cnt n=%0d got=%0d exp=%0d", n, stall_cnt, m_cnt);
            end
`endif
        end
        rst_n = 1'b1;
        flush = 1'b0;
    endtask

`ifdef HAZARD_STAT_EN
    task automatic test_stall_stats();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_instr(C_LW, 1, 5, 0);
            step();
            set_instr(C_RTYPE, 5, 2, 3);
            step();
            step();
        end
        checks++;
        if (stall_cnt !== 16'd3) begin
            errors++;
            $display("FAIL stat_three got=%0d exp=3", stall_cnt);
        end
        force dut.cnt_q = 16'hFFFE;
        #1;
        release dut.cnt_q;
        m_cnt = 16'hFFFE;
        for (int k = 0; k < 3; k++) begin
            set_instr(C_LW, 1, 6, 0);
            step();
            set_instr(C_SW, 6, 6, 0);
            step();
            step();
        end
        checks++;
        if (stall_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL stat_saturate got=%h exp=ffff", stall_cnt);
        end
        set_instr(C_LW, 1, 8, 0);
        step();
        set_instr(C_RTYPE, 8, 1, 2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (stall_cnt !== 16'h0 || ex_valid !== 1'b0) begin
            errors++;
            $display("FAIL stat_reset got=%h/%b exp=0/0", stall_cnt, ex_valid);
        end
    endtask
`endif

    initial begin
        m_ex  = '0;
        m_cnt = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        set_instr(9'h0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_pass_through();
        test_load_use();
        test_zero_reg();
        test_flush();
        test_random();
`ifdef HAZARD_STAT_EN
        test_stall_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
